// File: rtl/ram_sdp_rd_stream_pkg.sv
// Shared types and helpers for the SDP RAM read-stream engine.
package ram_sdp_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // True when a newly issued read is guaranteed a free slot in the 2-entry skid buffer.
    function automatic logic issue_room(input logic [1:0] cnt, input logic inflight,
                                        input logic pop);
        logic [2:0] occ;
        occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'd2;
    endfunction

endpackage

// File: rtl/ram_sdp_rd_stream_if.sv
// Command, RAM read-port and output-stream signals of the read-stream engine.
interface ram_sdp_rd_stream_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] cmd_addr;
    logic [AWIDTH-1:0] cmd_len;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWIDTH-1:0] ram_rd_addr;
    logic              ram_rd_ena;
    logic [DWIDTH-1:0] ram_rd_data;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;

    modport slave (
        input  cmd_addr, cmd_len, cmd_valid, ram_rd_data, out_ready,
        output cmd_ready, ram_rd_addr, ram_rd_ena, out_data, out_valid, out_last, busy
    );

    modport master (
        output cmd_addr, cmd_len, cmd_valid, ram_rd_data, out_ready,
        input  cmd_ready, ram_rd_addr, ram_rd_ena, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/ram_sdp_rd_skid.sv
// Two-entry synchronous skid FIFO with a registered head; count feeds the read-issue rule.
module ram_sdp_rd_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= push_data;
                    else               tail_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Full buffer: shift tail forward and refill it in the same cycle.
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end else begin
                        head_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = head_q;
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;
endmodule

// File: rtl/ram_sdp_rd_stream.sv
// Burst read engine: RAM read port to valid/ready stream with full backpressure.
// Optional macro RAM_SDP_RD_STREAM_LAST_EN adds an out_last flag on the final word of each burst.
module ram_sdp_rd_stream
    import ram_sdp_rd_stream_pkg::*;
#(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    ram_sdp_rd_stream_if.slave bus
);
    localparam logic [AWIDTH-1:0] ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] rem_q;
    logic              inflight_p1;
    logic              rd_ena;
    logic              pop;
    logic              buf_valid;
    logic [1:0]        buf_cnt;

`ifdef RAM_SDP_RD_STREAM_LAST_EN
    localparam int FW = DWIDTH + 1;
    logic          last_p1;
    logic [FW-1:0] push_word, head_word;

    always_ff @(posedge clk) begin
        if (rst) last_p1 <= 1'b0;
        else     last_p1 <= rd_ena && (rem_q == '0);
    end

    assign push_word    = {last_p1, bus.ram_rd_data};
    assign bus.out_last = buf_valid & head_word[DWIDTH];
`else
    localparam int FW = DWIDTH;
    logic [FW-1:0] push_word, head_word;

    assign push_word    = bus.ram_rd_data;
    assign bus.out_last = 1'b0;
`endif

    assign pop = buf_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        rd_ena  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) state_d = ST_RUN;
            ST_RUN: begin
                rd_ena = issue_room(buf_cnt, inflight_p1, pop);
                if (rd_ena && (rem_q == '0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: if ((buf_cnt == 2'd0) && !inflight_p1 && !pop) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_p1 <= rd_ena;
            if ((state_q == ST_IDLE) && bus.cmd_valid) begin
                addr_q <= bus.cmd_addr;
                rem_q  <= bus.cmd_len;
            end else if (rd_ena) begin
                addr_q <= addr_q + ONE;
                rem_q  <= rem_q - ONE;
            end
        end
    end

    // RAM data lands one cycle after issue; the in-flight flag is its push strobe.
    ram_sdp_rd_skid #(.WIDTH(FW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_p1),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .valid     (buf_valid),
        .count     (buf_cnt)
    );

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ram_rd_addr = addr_q;
    assign bus.ram_rd_ena  = rd_ena;
    assign bus.out_valid   = buf_valid;
    assign bus.out_data    = head_word[DWIDTH-1:0];
endmodule

// File: tb/tb_ram_sdp_rd_stream.sv
// Self-checking bench for ram_sdp_rd_stream with a behavioural RAM and burst reference model.
`timescale 1ns/1ps
module tb_ram_sdp_rd_stream;
    localparam int AWIDTH = 4;
    localparam int DWIDTH = 8;
    localparam int DEPTH  = 1 << AWIDTH;
`ifdef RAM_SDP_RD_STREAM_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [DWIDTH-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    ram_sdp_rd_stream_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

    ram_sdp_rd_stream #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM: registered read, one cycle latency.
    always @(posedge clk) if (bus.ram_rd_ena) bus.ram_rd_data <= mem[bus.ram_rd_addr];

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = DWIDTH'($urandom);
    endtask

    function automatic logic [DWIDTH-1:0] word_at(input logic [AWIDTH-1:0] a, input int k);
        return mem[(int'(a) + k) % DEPTH];
    endfunction

    task automatic send_cmd(input logic [AWIDTH-1:0] a, input logic [AWIDTH-1:0] l);
        int n = 0;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout cmd_ready=%b expected=1", bus.cmd_ready);
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy=%b expected=0", bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 7;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        if (bus.ram_rd_ena !== 1'b0) begin errors++; $display("FAIL reset_rd_ena got=%b exp=0", bus.ram_rd_ena); end
        if (bus.ram_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", bus.ram_rd_addr); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        @(posedge clk);
        #1;
    endtask

    // addr=5 len=3, RAM[i]=i, out_ready high: exact cycle-by-cycle timing.
    task automatic test_latency();
        logic exp_ena, exp_vld, exp_busy;
        for (int i = 0; i < DEPTH; i++) mem[i] = DWIDTH'(i);
        bus.out_ready = 1'b1;
        send_cmd(4'd5, 4'd3);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            exp_ena  = (cyc >= 1 && cyc <= 4);
            exp_vld  = (cyc >= 3 && cyc <= 6);
            exp_busy = (cyc <= 7);
            checks += 4;
            if (bus.ram_rd_ena !== exp_ena) begin errors++; $display("FAIL lat_rd_ena cyc=%0d got=%b exp=%b", cyc, bus.ram_rd_ena, exp_ena); end
            if (bus.out_valid !== exp_vld) begin errors++; $display("FAIL lat_out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_vld); end
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL lat_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
            if (bus.cmd_ready !== !exp_busy) begin errors++; $display("FAIL lat_cmd_ready cyc=%0d got=%b exp=%b", cyc, bus.cmd_ready, !exp_busy); end
            if (exp_ena) begin
                checks++;
                if (bus.ram_rd_addr !== AWIDTH'(5 + cyc - 1)) begin errors++; $display("FAIL lat_rd_addr cyc=%0d got=%0d exp=%0d", cyc, bus.ram_rd_addr, 5 + cyc - 1); end
            end
            if (exp_vld) begin
                checks++;
                if (bus.out_data !== DWIDTH'(5 + cyc - 3)) begin errors++; $display("FAIL lat_out_data cyc=%0d got=%0d exp=%0d", cyc, bus.out_data, 5 + cyc - 3); end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Burst starting at 14 must wrap through 0.
    task automatic test_wrap();
        logic [DWIDTH-1:0] exp_q[$];
        logic [AWIDTH-1:0] addr_q[$];
        logic [DWIDTH-1:0] d;
        logic [AWIDTH-1:0] ea;
        int cyc = 0;
        fill_random();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(word_at(4'd14, k));
            addr_q.push_back(AWIDTH'((14 + k) % DEPTH));
        end
        bus.out_ready = 1'b1;
        send_cmd(4'd14, 4'd3);
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (bus.ram_rd_ena) begin
                checks++;
                ea = (addr_q.size() > 0) ? addr_q.pop_front() : 'x;
                if (bus.ram_rd_addr !== ea) begin errors++; $display("FAIL wrap_rd_addr got=%0d exp=%0d", bus.ram_rd_addr, ea); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                d = exp_q.pop_front();
                if (bus.out_data !== d) begin errors++; $display("FAIL wrap_data got=%0h exp=%0h", bus.out_data, d); end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_count missing=%0d exp=0", exp_q.size()); end
        wait_idle();
    endtask

    // out_ready pattern 1-0-0-1: no loss, order kept, at most 2 words outstanding.
    task automatic test_backpressure();
        logic [DWIDTH-1:0] exp_q[$];
        logic [DWIDTH-1:0] d;
        int issued = 0, popped = 0, cyc = 0;
        int ena, pop;
        fill_random();
        for (int k = 0; k < 8; k++) exp_q.push_back(word_at(4'd0, k));
        bus.out_ready = 1'b1;
        send_cmd(4'd0, 4'd7);
        while ((exp_q.size() > 0 || issued < 8) && cyc < 120) begin
            bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            @(negedge clk);
            ena = int'(bus.ram_rd_ena);
            pop = int'(bus.out_valid & bus.out_ready);
            checks++;
            if (issued + ena - popped - pop > 2) begin errors++; $display("FAIL bp_occupancy got=%0d exp<=2", issued + ena - popped - pop); end
            if (ena != 0) begin
                checks++;
                if (bus.ram_rd_addr !== AWIDTH'(issued)) begin errors++; $display("FAIL bp_rd_addr got=%0d exp=%0d", bus.ram_rd_addr, issued); end
            end
            if (pop != 0) begin
                checks++;
                d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (bus.out_data !== d) begin errors++; $display("FAIL bp_data got=%0h exp=%0h", bus.out_data, d); end
            end
            issued += ena;
            popped += pop;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks += 2;
        if (issued != 8) begin errors++; $display("FAIL bp_issue_count got=%0d exp=8", issued); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_word_count missing=%0d exp=0", exp_q.size()); end
        bus.out_ready = 1'b1;
        wait_idle();
    endtask

    // len=0 burst with a second command held valid: accepted only once back in IDLE.
    task automatic test_len0_hold();
        logic [DWIDTH-1:0] exp_q[$];
        logic [DWIDTH-1:0] d;
        logic [AWIDTH-1:0] a1, a2, l2;
        int acc = -1;
        int cyc = 1;
        fill_random();
        a1 = AWIDTH'($urandom);
        a2 = AWIDTH'($urandom);
        l2 = AWIDTH'($urandom_range(1, 5));
        exp_q.push_back(word_at(a1, 0));
        for (int k = 0; k <= int'(l2); k++) exp_q.push_back(word_at(a2, k));
        bus.out_ready = 1'b1;
        bus.cmd_addr  = a1;
        bus.cmd_len   = '0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_addr = a2;
        bus.cmd_len  = l2;
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            if (acc < 0 && cyc < 5) begin
                checks++;
                if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL len0_cmd_ready cyc=%0d got=%b exp=0", cyc, bus.cmd_ready); end
            end
            if (acc < 0 && bus.cmd_valid && bus.cmd_ready) acc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                d = exp_q.pop_front();
                if (bus.out_data !== d) begin errors++; $display("FAIL len0_data got=%0h exp=%0h", bus.out_data, d); end
            end
            @(posedge clk);
            #1;
            if (acc == cyc) bus.cmd_valid = 1'b0;
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        checks += 2;
        if (acc != 5) begin errors++; $display("FAIL len0_accept_cycle got=%0d exp=5", acc); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL len0_word_count missing=%0d exp=0", exp_q.size()); end
        wait_idle();
    endtask

    // Reset two cycles into a 16-word burst, then a fresh burst.
    task automatic test_reset_midburst();
        logic [DWIDTH-1:0] exp_q[$];
        logic [DWIDTH-1:0] d;
        logic [AWIDTH-1:0] a;
        int cyc = 0;
        fill_random();
        bus.out_ready = 1'b1;
        send_cmd(AWIDTH'($urandom), 4'd15);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 5;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.ram_rd_ena !== 1'b0) begin errors++; $display("FAIL rstmid_rd_ena got=%b exp=0", bus.ram_rd_ena); end
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got=%b exp=1", bus.cmd_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL rstmid_out_data got=%0h exp=0", bus.out_data); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_data out_valid=%b exp=0", bus.out_valid); end
        @(posedge clk);
        #1;
        a = AWIDTH'($urandom);
        for (int k = 0; k < 6; k++) exp_q.push_back(word_at(a, k));
        send_cmd(a, 4'd5);
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                d = exp_q.pop_front();
                if (bus.out_data !== d) begin errors++; $display("FAIL rstmid_after_data got=%0h exp=%0h", bus.out_data, d); end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_after_count missing=%0d exp=0", exp_q.size()); end
        wait_idle();
    endtask

    // Random bursts (including len=2 and a full wrap) under random out_ready; checks data and out_last.
    task automatic test_random_last();
        logic [DWIDTH-1:0] exp_q[$];
        logic [DWIDTH-1:0] d;
        logic [AWIDTH-1:0] a, l;
        logic exp_last;
        int idx, cyc;
        for (int b = 0; b < 8; b++) begin
            fill_random();
            a = AWIDTH'($urandom);
            if (b == 0)      l = 4'd2;
            else if (b == 1) l = 4'd15;
            else             l = AWIDTH'($urandom);
            exp_q.delete();
            for (int k = 0; k <= int'(l); k++) exp_q.push_back(word_at(a, k));
            idx = 0;
            cyc = 0;
            bus.out_ready = 1'b1;
            send_cmd(a, l);
            while (exp_q.size() > 0 && cyc < 200) begin
                bus.out_ready = ($urandom_range(0, 9) < 6);
                @(negedge clk);
                if (!bus.out_valid) begin
                    checks++;
                    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rnd_last_idle got=%b exp=0", bus.out_last); end
                end else if (bus.out_ready) begin
                    exp_last = LAST_EN && (idx == int'(l));
                    checks += 2;
                    d = exp_q.pop_front();
                    if (bus.out_data !== d) begin errors++; $display("FAIL rnd_data burst=%0d idx=%0d got=%0h exp=%0h", b, idx, bus.out_data, d); end
                    if (bus.out_last !== exp_last) begin errors++; $display("FAIL rnd_last burst=%0d idx=%0d got=%b exp=%b", b, idx, bus.out_last, exp_last); end
                    idx++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_count burst=%0d missing=%0d exp=0", b, exp_q.size()); end
            bus.out_ready = 1'b1;
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_backpressure();
        test_len0_hold();
        test_reset_midburst();
        test_random_last();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
